// File: rtl/me_ctu_scheduler_if.sv
// me_ctu_scheduler_if: frame control, PE array and writeback handshake bundle for the CTU scheduler
interface me_ctu_scheduler_if #(parameter int DIM_W = 6);
    logic             frame_start, frame_abort, pe_done, wb_ack;
    logic [DIM_W-1:0] ctu_cols, ctu_rows, ctu_x, ctu_y;
    logic             begin_prepare, wb_req, busy, frame_done, err;
    logic [11:0]      ctu_count;
    modport master (
        output frame_start, frame_abort, ctu_cols, ctu_rows, pe_done, wb_ack,
        input  begin_prepare, wb_req, ctu_x, ctu_y, ctu_count, busy, frame_done, err
    );
    modport slave (
        input  frame_start, frame_abort, ctu_cols, ctu_rows, pe_done, wb_ack,
        output begin_prepare, wb_req, ctu_x, ctu_y, ctu_count, busy, frame_done, err
    );
endinterface

// File: rtl/me_ctu_scheduler.sv
// me_ctu_scheduler: raster-order CTU launch/search/writeback sequencer; ME_TIMEOUT_EN adds a sticky SEARCH timeout
module me_ctu_scheduler #(
    parameter int DIM_W          = 6,
    parameter int SEARCH_TIMEOUT = 4095
) (
    input logic               clk,
    input logic               rst_n,
    me_ctu_scheduler_if.slave s
);
    typedef enum logic [2:0] {IDLE, LAUNCH, SEARCH, WB, ADVANCE, DONE} state_t;
    state_t           state, nxt;
    logic [DIM_W-1:0] cols_r, rows_r;
    logic             dims_ok, start_ok, last_x, last_y, tmo;
    always_comb begin
        dims_ok  = s.ctu_cols != '0 && s.ctu_rows != '0;
        start_ok = state == IDLE && s.frame_start && !s.frame_abort && dims_ok;
        last_x   = s.ctu_x == cols_r - DIM_W'(1);
        last_y   = s.ctu_y == rows_r - DIM_W'(1);
        case (state)
            IDLE:    nxt = start_ok ? LAUNCH : IDLE;
            LAUNCH:  nxt = SEARCH;
            SEARCH:  nxt = s.pe_done ? WB : tmo ? ADVANCE : SEARCH;
            WB:      nxt = s.wb_ack ? ADVANCE : WB;
            ADVANCE: nxt = last_x && last_y ? DONE : LAUNCH;
            default: nxt = IDLE;
        endcase
        if (s.frame_abort) nxt = IDLE;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cols_r          <= '0;
            rows_r          <= '0;
            s.begin_prepare <= 1'b0;
            s.wb_req        <= 1'b0;
            s.busy          <= 1'b0;
            s.frame_done    <= 1'b0;
            s.ctu_x         <= '0;
            s.ctu_y         <= '0;
            s.ctu_count     <= '0;
        end else begin
            state           <= nxt;
            s.begin_prepare <= nxt == LAUNCH;
            s.wb_req        <= nxt == WB;
            s.busy          <= nxt != IDLE;
            s.frame_done    <= nxt == DONE ||
                               (state == IDLE && s.frame_start && !s.frame_abort && !dims_ok);
            if (start_ok) begin
                cols_r      <= s.ctu_cols;
                rows_r      <= s.ctu_rows;
                s.ctu_x     <= '0;
                s.ctu_y     <= '0;
                s.ctu_count <= '0;
            end else if (state == ADVANCE && !s.frame_abort) begin
                s.ctu_count <= s.ctu_count + 12'd1;
                if (!(last_x && last_y)) begin
                    s.ctu_x <= last_x ? '0 : s.ctu_x + DIM_W'(1);
                    s.ctu_y <= last_x ? s.ctu_y + DIM_W'(1) : s.ctu_y;
                end
            end
        end
    end
`ifdef ME_TIMEOUT_EN
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign tmo = state == SEARCH && !s.pe_done && tcnt == TW'(SEARCH_TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            s.err <= 1'b0;
        end else begin
            tcnt <= state == SEARCH ? tcnt + 1'b1 : '0;
            if (start_ok) s.err <= 1'b0;
            else if (tmo && !s.frame_abort) s.err <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign s.err = 1'b0;
`endif
endmodule
